fifo_byte_serializer: RTL
=========================

// Module: fifo_byte_serializer
// PURPOSE
//  Downstream consumer of the 16x32 SimpleFIFO. Pops 32-bit words via the FIFO read port
//  and emits each one as a stream of bytes on a valid/ready output, LSB first by default.
//  Sits between the FIFO and a byte-wide sink (UART TX / byte bus). Back-pressure from
//  the sink stalls popping, so the FIFO absorbs bursts.
// PARAMETERS
//  WORD_W       32  FIFO word width; must be a multiple of BYTE_W
//  BYTE_W        8  output symbol width
//  LSB_FIRST     1  1: byte 0 = word[BYTE_W-1:0] goes first; 0: MSB byte first
//  ACK_TIMEOUT   4  cycles in WAIT with no rd_ack/rd_err before abort (min 2)
//  CNT_W        16  width of word_count
// PORTS
//  clk          in   1        rising-edge clock
//  reset        in   1        asynchronous, active-high reset
//  fifo_empty   in   1        FIFO empty flag
//  fifo_rd_ack  in   1        FIFO read acknowledge; fifo_d_out valid this cycle
//  fifo_rd_err  in   1        FIFO read error (read attempted while empty)
//  fifo_d_out   in   WORD_W   FIFO read data
//  fifo_rd_en   out  1        FIFO read enable, single-cycle pulse
//  out_data     out  BYTE_W   output byte
//  out_valid    out  1        out_data valid
//  out_ready    in   1        sink accepts out_data when out_valid & out_ready
//  out_last     out  1        high with the final byte of each word
//  busy         out  1        high in any state other than IDLE
//  err          out  1        sticky: set on rd_err or timeout; cleared only by reset
//  word_count   out  CNT_W    words fully transmitted; wraps to 0 after all-ones
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; fifo_rd_en, out_valid, out_last, busy, err=0;
//   out_data=0, word_count=0, byte index=0; any word in flight is discarded.
//  NB = WORD_W/BYTE_W. FIFO contract: rd_ack/rd_err arrive the cycle after rd_en is
//   sampled; fifo_d_out is valid in the rd_ack cycle only.
//  FSM (registered outputs):
//   IDLE: if !fifo_empty -> fifo_rd_en=1 for one cycle, go WAIT. Else stay.
//   WAIT: fifo_rd_en=0. rd_ack -> latch fifo_d_out into shift reg, idx=0, go SEND.
//         rd_err (ack not also high) -> err=1, go IDLE. ack and err together: ack wins.
//         No response for ACK_TIMEOUT cycles -> err=1, go IDLE.
//   SEND: out_valid=1, out_data=byte[idx] (idx or NB-1-idx per LSB_FIRST),
//         out_last=(idx==NB-1). On out_valid&out_ready: idx++; on last byte accepted:
//         word_count++, and if !fifo_empty -> pulse fifo_rd_en, go WAIT (back-to-back
//         pop, no IDLE bubble); else go IDLE, out_valid=0.
//  Output stability: while out_valid & !out_ready, out_data/out_last hold constant.
//  Latency: rd_en pulse -> first out_valid = 2 cycles (ack cycle + latch).
//  Throughput: with out_ready=1, NB bytes per NB+2 cycles (gap of 2 per word).
//  fifo_empty is only sampled in IDLE and on the last-byte handshake; never pop twice
//   without an intervening ack/err/timeout (at most one read outstanding).
//  word_count wraps 2^CNT_W-1 -> 0 silently; err does not stop operation.
// STRUCTURE
//  Package fifo_ser_pkg: state enum {IDLE, WAIT, SEND}, NB localparam helper, CNT_W default.
//  Single module; optional sub-module ser_shift (WORD_W word -> BYTE_W lanes, index select)
//  if reused by the UART TX path. Timeout counter is $clog2(ACK_TIMEOUT+1) bits.
// TESTING
//  1 Reset mid-SEND (after 2 bytes accepted): all outputs return to reset values
//    asynchronously; after release, next word starts at byte 0.
//  2 One word 32'h6b3c_3ad9, out_ready=1: fifo_rd_en 1 pulse; bytes d9,3a,3c,6b with
//    out_last only on 6b; word_count=1; back to IDLE, busy=0.
//  3 16 words preloaded (FIFO full), out_ready=1: no IDLE between words, 64 bytes in
//    order, 6 cycles/word, word_count=16, FIFO empty at end, err=0.
//  4 Back-pressure: out_ready toggles 1,0,0,1... on 32'hf414_ecaa: out_data held stable
//    while stalled; bytes aa,ec,14,f4 each transferred exactly once.
//  5 Force rd_err in WAIT (model FIFO going empty): err=1, no bytes emitted,
//    word_count unchanged; next valid word still serialised correctly, err stays 1.
//  6 Model withholds ack: after ACK_TIMEOUT=4 cycles in WAIT -> err=1, IDLE; LSB_FIRST=0
//    build emits c3,ed,57,cf for 32'hc3ed_57cf.

Source files
------------

// File: rtl/fifo_ser_pkg.sv
// Shared types and sizing helpers for the FIFO-to-byte-stream serializer.
package fifo_ser_pkg;

    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        SEND = 2'd2
    } ser_state_e;

    // Number of output symbols carried by one FIFO word.
    function automatic int calc_nb(input int word_w, input int byte_w);
        return word_w / byte_w;
    endfunction

    // Byte-index width, kept at least one bit wide so single-lane builds still elaborate.
    function automatic int calc_idx_w(input int nb);
        return (nb > 1) ? $clog2(nb) : 1;
    endfunction

endpackage

// File: rtl/fifo_byte_serializer_shift.sv
// Lane selector: picks byte number idx of a word, counting from either the LSB or the MSB end.
module ser_shift
    import fifo_ser_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int BYTE_W    = 8,
    parameter bit LSB_FIRST = 1'b1,
    parameter int IDX_W     = calc_idx_w(calc_nb(WORD_W, BYTE_W))
) (
    input  logic [WORD_W-1:0] word,
    input  logic [IDX_W-1:0]  idx,
    output logic [BYTE_W-1:0] lane
);

    localparam int NB = calc_nb(WORD_W, BYTE_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

    logic [IDX_W-1:0] lane_idx;

    always_comb begin
        lane_idx = LSB_FIRST ? idx : (LAST_IDX - idx);
        lane     = word[lane_idx * BYTE_W +: BYTE_W];
    end

endmodule

// File: rtl/fifo_byte_serializer.sv
// Pops words from SimpleFIFO and streams them out one byte at a time on a valid/ready port.
// At most one read is outstanding; sink back-pressure stalls popping so the FIFO absorbs bursts.
module fifo_byte_serializer
    import fifo_ser_pkg::*;
#(
    parameter int WORD_W      = 32,
    parameter int BYTE_W      = 8,
    parameter bit LSB_FIRST   = 1'b1,
    parameter int ACK_TIMEOUT = 4,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fifo_empty,
    input  logic              fifo_rd_ack,
    input  logic              fifo_rd_err,
    input  logic [WORD_W-1:0] fifo_d_out,
    output logic              fifo_rd_en,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              err,
    output logic [CNT_W-1:0]  word_count
);

    localparam int NB    = calc_nb(WORD_W, BYTE_W);
    localparam int IDX_W = calc_idx_w(NB);
    localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    ser_state_e        state_q, state_d;
    logic              rd_en_q, rd_en_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              out_valid_q, out_valid_d;
    logic [BYTE_W-1:0] out_data_q, out_data_d;
    logic              out_last_q, out_last_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [WORD_W-1:0] src_word;
    logic [IDX_W-1:0]  src_idx;
    logic [BYTE_W-1:0] next_lane;
    logic              handshake;

    // The byte presented next is either byte 0 of the word arriving on the ack,
    // or the following byte of the word already held.
    always_comb begin
        src_word = word_q;
        src_idx  = idx_q + 1'b1;
        if (state_q == WAIT) begin
            src_word = fifo_d_out;
            src_idx  = '0;
        end
    end

    ser_shift #(
        .WORD_W    (WORD_W),
        .BYTE_W    (BYTE_W),
        .LSB_FIRST (LSB_FIRST),
        .IDX_W     (IDX_W)
    ) u_shift (
        .word (src_word),
        .idx  (src_idx),
        .lane (next_lane)
    );

    assign handshake = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        rd_en_d     = 1'b0;
        word_d      = word_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        err_d       = err_q;
        count_d     = count_q;

        case (state_q)
            IDLE: begin
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
                if (!fifo_empty) begin
                    rd_en_d = 1'b1;
                    tmo_d   = '0;
                    state_d = WAIT;
                end
            end

            // An ack wins over a simultaneous error; silence long enough aborts the read.
            WAIT: begin
                if (fifo_rd_ack) begin
                    word_d      = fifo_d_out;
                    idx_d       = '0;
                    out_valid_d = 1'b1;
                    out_data_d  = next_lane;
                    out_last_d  = (src_idx == LAST_IDX);
                    state_d     = SEND;
                end else if (fifo_rd_err || (tmo_q == TMO_LAST)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            SEND: begin
                if (handshake) begin
                    if (idx_q == LAST_IDX) begin
                        count_d     = count_q + 1'b1;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                        if (!fifo_empty) begin
                            rd_en_d = 1'b1;
                            tmo_d   = '0;
                            state_d = WAIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        idx_d      = src_idx;
                        out_data_d = next_lane;
                        out_last_d = (src_idx == LAST_IDX);
                    end
                end
            end

            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_en_q     <= 1'b0;
            word_q      <= '0;
            idx_q       <= '0;
            tmo_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            rd_en_q     <= rd_en_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
            count_q     <= count_d;
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign busy       = (state_q != IDLE);
    assign err        = err_q;
    assign word_count = count_q;

endmodule
